// File: rtl/lut_cfg_loader_pkg.sv
// rtl/lut_cfg_loader_pkg.sv - shared state encoding and table sizing for lut_cfg_loader
package lut_cfg_loader_pkg;

  localparam int LUT_N_IN_DEF  = 3;
  localparam int LUT_DEPTH_DEF = 1 << LUT_N_IN_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SWAP = 2'd2
  } lut_state_e;

  function automatic int lut_depth(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/lut_cfg_shift.sv
// rtl/lut_cfg_shift.sv - shadow truth-table shift register and received-bit counter
module lut_cfg_shift
  import lut_cfg_loader_pkg::*;
#(
  parameter int DEPTH = LUT_DEPTH_DEF,
  parameter int CNT_W = LUT_N_IN_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             cfg_bit,
  output logic [DEPTH-1:0] shadow,
  output logic             last_bit
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0] cnt;

  // The counter wraps naturally to zero on the final bit of a table.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (clear) begin
      cnt    <= '0;
    end else if (shift_en) begin
      shadow <= {shadow[DEPTH-2:0], cfg_bit};
      cnt    <= cnt + 1'b1;
    end
  end

  assign last_bit = (cnt == CNT_LAST);

endmodule

// File: rtl/lut_cfg_loader.sv
// rtl/lut_cfg_loader.sv - serially reloadable N-input LUT with atomic table swap
module lut_cfg_loader
  import lut_cfg_loader_pkg::*;
#(
  parameter int                          N_IN  = LUT_N_IN_DEF,
  parameter logic [(1 << N_IN)-1:0]      INIT  = '0,
  parameter int                          CNT_W = N_IN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  input  logic            cfg_abort,
  output logic            cfg_done,
  output logic            busy,
  input  logic            lut_valid,
  input  logic [N_IN-1:0] I,
  output logic            LO,
  output logic            O,
  output logic            O_valid
);

  localparam int DEPTH = lut_depth(N_IN);

  lut_state_e       state, state_nxt;
  logic [DEPTH-1:0] active_table;
  logic [DEPTH-1:0] shadow;
  logic             last_bit;
  logic             xfer;
  logic             clear;

  // An abort wins over a bit offered in the same cycle; SWAP ignores both.
  assign xfer  = cfg_valid && cfg_ready && !cfg_abort;
  assign clear = cfg_abort && (state != ST_SWAP);

  lut_cfg_shift #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (xfer),
    .clear    (clear),
    .cfg_bit  (cfg_bit),
    .shadow   (shadow),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b1;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (cfg_abort) begin
          state_nxt = ST_IDLE;
        end else if (xfer && last_bit) begin
          state_nxt = ST_SWAP;
        end
      end
      ST_SWAP: begin
        busy      = 1'b1;
        cfg_ready = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // cfg_done marks the first cycle in which the new table is visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_table <= INIT;
      cfg_done     <= 1'b0;
    end else begin
      cfg_done <= (state == ST_SWAP);
      if (state == ST_SWAP) begin
        active_table <= shadow;
      end
    end
  end

  assign LO = active_table[I];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      O       <= 1'b0;
      O_valid <= 1'b0;
    end else begin
      O_valid <= lut_valid;
      if (lut_valid) begin
        O <= active_table[I];
      end
    end
  end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb/tb_lut_cfg_loader.sv - randomized model-checked bench for lut_cfg_loader
module tb_lut_cfg_loader;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_ready;
  logic       cfg_abort = 1'b0;
  logic       cfg_done;
  logic       busy;
  logic       lut_valid = 1'b0;
  logic [2:0] I = 3'd0;
  logic       LO;
  logic       O;
  logic       O_valid;

  int total = 0;
  int bad   = 0;

  logic [7:0] init_v = 8'hE8;

  lut_cfg_loader #(
    .N_IN  (3),
    .INIT  (8'hE8),
    .CNT_W (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_abort (cfg_abort),
    .cfg_done  (cfg_done),
    .busy      (busy),
    .lut_valid (lut_valid),
    .I         (I),
    .LO        (LO),
    .O         (O),
    .O_valid   (O_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: count of accepted bits, accumulated value, pending swap.
  logic [7:0] m_active = 8'hE8;
  logic [7:0] m_acc    = 8'h00;
  logic [7:0] m_full   = 8'h00;
  int         m_n      = 0;
  logic       m_swap   = 1'b0;
  logic       m_done   = 1'b0;
  logic       m_o      = 1'b0;
  logic       m_ov     = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = init_v;
      m_acc    = 8'h00;
      m_n      = 0;
      m_swap   = 1'b0;
      m_done   = 1'b0;
      m_o      = 1'b0;
      m_ov     = 1'b0;
    end else begin
      if (lut_valid) begin
        m_o  = m_active[I];
        m_ov = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
      m_done = m_swap;
      if (m_swap) begin
        m_active = m_full;
        m_swap   = 1'b0;
      end else if (cfg_abort) begin
        m_n = 0;
      end else if (cfg_valid) begin
        m_acc = (m_acc << 1) | {7'b0, cfg_bit};
        m_n++;
        if (m_n == DEPTH) begin
          m_full = m_acc;
          m_swap = 1'b1;
          m_n    = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cfg_ready", cfg_ready, !m_swap);
    chk("busy", busy, m_swap || (m_n > 0));
    chk("cfg_done", cfg_done, m_done);
    chk("LO", LO, m_active[I]);
    chk("O", O, m_o);
    chk("O_valid", O_valid, m_ov);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lookup();
    lut_valid = 1'($urandom_range(0, 1));
    I         = 3'($urandom_range(0, 7));
  endtask

  task automatic lookup(input int i, input logic exp, input string nm);
    lut_valid = 1'b1;
    I         = 3'(i);
    step();
    lut_valid = 1'b0;
    chk(nm, O, exp);
    chk({nm, "_valid"}, O_valid, 1'b1);
  endtask

  // gap: 0 none, 1 idle cycle between bits, 2 random idle cycles
  task automatic send_bits(input logic [7:0] val, input int hi, input int lo, input int gap);
    for (int k = hi; k >= lo; k--) begin
      cfg_valid = 1'b1;
      cfg_bit   = val[k];
      rand_lookup();
      step();
      cfg_valid = 1'b0;
      lut_valid = 1'b0;
      if (k != 0 && (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1))) begin
        rand_lookup();
        step();
        lut_valid = 1'b0;
      end
    end
  endtask

  task automatic finish_swap(input int swap_i, input logic ab_swap,
                             output logic o_sw, output logic o_dn);
    chk("swap_ready", cfg_ready, 1'b0);
    chk("swap_busy", busy, 1'b1);
    cfg_abort = ab_swap;
    if (swap_i >= 0) begin
      lut_valid = 1'b1;
      I         = 3'(swap_i);
    end
    step();
    cfg_abort = 1'b0;
    lut_valid = 1'b0;
    chk("done_pulse", cfg_done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_ready", cfg_ready, 1'b1);
    o_sw = O;
    if (swap_i >= 0) begin
      lut_valid = 1'b1;
      I         = 3'(swap_i);
    end
    step();
    lut_valid = 1'b0;
    chk("done_end", cfg_done, 1'b0);
    o_dn = O;
  endtask

  task automatic load(input logic [7:0] val, input int gap);
    logic a, b;
    send_bits(val, 7, 0, gap);
    finish_swap(-1, 1'b0, a, b);
  endtask

  task automatic abort_load(input logic [7:0] val, input int nb, input int gap);
    send_bits(val, 7, 8 - nb, gap);
    cfg_abort = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    step();
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", cfg_ready, 1'b1);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("abort_no_done", cfg_done, 1'b0);
    end
  endtask

  initial begin
    logic o_sw, o_dn;
    logic [2:0] a3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_O", O, 1'b0);
    chk("rst_O_valid", O_valid, 1'b0);
    reset_n = 1'b1;
    step();

    // INIT is the 3-input majority function
    for (int i = 0; i < 8; i++) begin
      a3 = 3'(i);
      lookup(i, (32'(a3[0]) + 32'(a3[1]) + 32'(a3[2])) >= 2, "maj");
    end
    step();
    chk("O_valid_trail", O_valid, 1'b0);

    // XOR3, continuous, with an abort offered in the SWAP cycle
    send_bits(8'h96, 7, 0, 0);
    finish_swap(-1, 1'b1, o_sw, o_dn);
    lookup(1, 1'b1, "xor_I1");
    lookup(3, 1'b0, "xor_I3");

    // gapped 8'h01: old table is visible until the swap
    send_bits(8'h01, 7, 4, 1);
    lookup(0, 1'b0, "mid_load_I0");
    send_bits(8'h01, 3, 0, 1);
    finish_swap(-1, 1'b0, o_sw, o_dn);
    lookup(0, 1'b1, "gap_I0");

    abort_load(8'hFF, 5, 0);
    lookup(0, 1'b1, "abort_keep_I0");
    lookup(7, 1'b0, "abort_keep_I7");
    load(8'h80, 0);
    lookup(7, 1'b1, "x80_I7");
    lookup(0, 1'b0, "x80_I0");

    // lookup in the SWAP cycle sees the old table, on cfg_done the new one
    load(8'h00, 0);
    send_bits(8'h80, 7, 0, 0);
    finish_swap(7, 1'b0, o_sw, o_dn);
    chk("swap_cycle_O", o_sw, 1'b0);
    chk("done_cycle_O", o_dn, 1'b1);

    // asynchronous reset mid-load
    send_bits(8'h5A, 7, 4, 0);
    I = 3'd3;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ready", cfg_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", cfg_done, 1'b0);
    chk("arst_O", O, 1'b0);
    chk("arst_O_valid", O_valid, 1'b0);
    chk("arst_LO", LO, init_v[3]);
    #3;
    reset_n = 1'b1;
    step();
    load(8'h3C, 0);
    lookup(2, 1'b1, "x3c_I2");
    lookup(0, 1'b0, "x3c_I0");

    // randomized loads, aborts and lookups
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        abort_load(8'($urandom), $urandom_range(1, 7), 2);
      end else begin
        send_bits(8'($urandom), 7, 0, 2);
        finish_swap(-1, 1'($urandom_range(0, 1)), o_sw, o_dn);
      end
      for (int c = 0; c < 4; c++) begin
        rand_lookup();
        step();
      end
      lut_valid = 1'b0;
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lut_cfg_loader.md
Name: lut_cfg_loader

Overview:
- Dynamically reconfigurable N-input lookup stage.
- Serially loads a new 2^N-bit truth table into a shadow register through a valid/ready bit stream.
- Atomically swaps the shadow table into the active table once all bits have arrived.
- Serves lookups from the active table with a registered output and a combinational local output.
- Sits directly upstream of and around the fixed-INIT LUT primitives: the PicoBlaze-side controller feeds it configuration bits, and downstream logic consumes its lookup result.

Parameters:
- N_IN, 3, number of select inputs; table depth is 2^N_IN bits (3 gives 8 bits).
- INIT, 8'h00, active table value after reset; width 2^N_IN.
- CNT_W, 3, bit-counter width; must equal N_IN.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  configuration bit present on cfg_bit.
- cfg_bit  input  1  next table bit, MSB (entry 2^N_IN-1) first.
- cfg_ready  output  1  loader accepts a bit this cycle.
- cfg_abort  input  1  discard a partial load, return to IDLE.
- cfg_done  output  1  one-cycle pulse on the cycle the new table becomes active.
- busy  output  1  load in progress (state LOAD or SWAP).
- lut_valid  input  1  lookup request on I.
- I  input  N_IN  lookup address; I[0] is the LSB.
- LO  output  1  combinational active_table[I].
- O  output  1  registered lookup result.
- O_valid  output  1  O holds a result for the lookup accepted one cycle earlier.

Behaviour:
- Reset, asynchronous on reset_n low:
  - active_table=INIT, shadow=0, cnt=0, state=IDLE.
  - O=0, O_valid=0, cfg_done=0, busy=0, cfg_ready=1.
  - Reset mid-load discards the partial shadow; the active table returns to INIT.
- States:
  - IDLE: cfg_ready=1. A bit is transferred when cfg_valid&cfg_ready. On the first transfer, shift the bit into shadow, set cnt=1, go to LOAD.
  - LOAD: cfg_ready=1, busy=1. Each transfer does shadow <= {shadow[2^N_IN-2:0], cfg_bit} and cnt++. The transfer with cnt==2^N_IN-1 (the 8th bit for N_IN=3) goes to SWAP, and the counter wraps to 0.
  - SWAP: cfg_ready=0, busy=1, lasts one cycle. active_table <= shadow, cfg_done=1 on the following cycle, then go to IDLE.
- Transfer rules:
  - cfg_valid low in LOAD stalls; cnt and shadow hold indefinitely.
  - cfg_abort in IDLE or LOAD: go to IDLE, cnt=0, active table unchanged, no cfg_done. A bit offered in the same cycle is dropped.
  - cfg_abort in SWAP is ignored; the swap completes.
- Lookup rules:
  - LO = active_table[I], purely combinational.
  - On lut_valid: O <= active_table[I] and O_valid <= 1 next cycle. Without lut_valid, O holds and O_valid <= 0.
  - Lookup latency is 1 cycle. The bench does not check for X on I when lut_valid=0.
- Lookup in the swap cycle: a lookup registered in the SWAP cycle uses the old table. The first lookup accepted on the cycle cfg_done is high uses the new table.
- Loading never stalls lookups; lookups never stall loading.
- Bit ordering: after a full load of bits b7..b0 (b7 first), active_table == {b7,...,b0}, i.e. entry k = bk.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=2'd0, ST_LOAD=2'd1, ST_SWAP=2'd2.
  - the 2^N_IN table-width localparam.
- One natural sub-module: lut_cfg_shift, containing the shadow shift register and bit counter, with outputs shadow, last_bit. The FSM, active table and lookup register stay in the top.

Test Plan:
- Reset with INIT=8'hE8 (majority function): lookups I=3,5,6,7 -> O=1; I=0,1,2,4 -> O=0. O_valid trails lut_valid by 1 cycle.
- Continuous load of 8'h96 (XOR3), cfg_valid held high 8 cycles:
  - busy high, cfg_ready low exactly 1 cycle (SWAP), then cfg_done pulse.
  - Afterwards I=1 -> O=1 and I=3 -> O=0.
- Load 8'h01 with cfg_valid gapped every other cycle: cnt holds during gaps; the table changes only after the 8th bit; lookups I=0 mid-load return the old table value.
- Abort after 5 bits of 8'hFF: no cfg_done, table unchanged. A following full load of 8'h80 -> I=7 gives 1, I=0 gives 0.
- Lookup I=7 issued in the SWAP cycle while loading 8'h80 over 8'h00 -> O=0. The same lookup on the cfg_done cycle -> O=1.
- reset_n pulsed low asynchronously (mid-clock) after 4 bits -> all outputs immediately at reset values. A subsequent full load of 8'h3C behaves normally and returns I=2 -> 1.
